// File: rtl/rf_dump.sv
// rf_dump: debug reader on register-file read port B. It streams a wrapping range
// of registers over valid/ready and keeps a running 16-bit checksum of accepted beats.
module rf_dump #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    first_addr,
  input  logic [3:0]    count,
  output logic [2:0]    rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  if (NREGS != 8) begin : g_nregs_check
    $error("rf_dump: NREGS must be 8 (3-bit addressing)");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [2:0]    r_ptr;
  logic [3:0]    r_remaining;
  logic [DW-1:0] r_out_data;
  logic [2:0]    r_out_addr;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_checksum;

  logic [3:0]    w_n;
  logic          w_start_ok;
  logic          w_zero_done;
  logic          w_accept;
  logic          w_capture;
  logic          w_finish;
  logic          w_stop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start && !abort && (w_n != 4'd0)) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = abort ? S_IDLE : S_SEND;
      S_SEND: if (abort || (r_out_valid && out_ready && r_out_last)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control strobes that steer the registered outputs.
  always_comb begin
    w_n         = (count > 4'd8) ? 4'd8 : count;
    w_start_ok  = 1'b0;
    w_zero_done = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    w_stop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_start_ok  = start && !abort;
        w_zero_done = w_start_ok && (w_n == 4'd0);
      end
      S_LOAD: begin
        w_capture = !abort;
        w_stop    = abort;
      end
      S_SEND: begin
        // A handshake coinciding with abort is not counted.
        w_accept  = r_out_valid && out_ready && !abort;
        w_capture = w_accept && !r_out_last;
        w_finish  = w_accept && r_out_last;
        w_stop    = abort || w_finish;
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= w_zero_done || w_finish;
      r_busy <= (w_state_nxt != S_IDLE);

      if (w_start_ok) begin
        r_checksum <= '0;
        if (w_n != 4'd0) begin
          r_ptr       <= first_addr;
          r_remaining <= w_n;
        end
      end

      if (w_accept) r_checksum <= r_checksum + r_out_data;

      if (w_capture) begin
        r_out_data  <= rd_data;
        r_out_addr  <= r_ptr;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_remaining == 4'd1);
        r_ptr       <= r_ptr + 3'd1;
        r_remaining <= r_remaining - 4'd1;
      end else if (w_stop) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign rd_addr   = r_ptr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;

endmodule
